// File: rtl/mem_bus_master.sv
// Clocked initiator for the 16-entry program/data memory bus: accepts fetch/load/store
// requests, sequences the memory pins through a programmable access window, returns the byte.
module mem_bus_master #(
   parameter int unsigned ACCESS_CYCLES = 1,
   parameter logic [3:0]  FETCH_OPCODE  = 4'hF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_kind,
   input  logic [3:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_err,
   output logic [3:0] mem_addr,
   output logic       mem_oe_n,
   output logic [3:0] mem_op_code,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   output logic       busy,
   output logic [7:0] xact_count
);

   localparam logic [1:0] KindFetch = 2'b00;
   localparam logic [1:0] KindLoad  = 2'b01;
   localparam logic [1:0] KindStore = 2'b10;
   localparam logic [1:0] KindIll   = 2'b11;
   localparam logic [3:0] LastCnt   = 4'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e     state;
   logic [1:0] kind_q;
   logic [3:0] addr_q;
   logic [7:0] wdata_q;
   logic [3:0] wait_cnt;

   assign req_ready = (state == StIdle);
   assign busy      = (state != StIdle);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StIdle;
         kind_q      <= KindFetch;
         addr_q      <= 4'h0;
         wdata_q     <= 8'h00;
         wait_cnt    <= 4'h0;
         mem_oe_n    <= 1'b1;
         mem_addr    <= 4'h0;
         mem_op_code <= FETCH_OPCODE;
         mem_wdata   <= 8'h00;
         rsp_valid   <= 1'b0;
         rsp_data    <= 8'h00;
         rsp_err     <= 1'b0;
         xact_count  <= 8'h00;
      end else begin
         unique case (state)
            StIdle: begin
               if (req_valid) begin
                  kind_q  <= req_kind;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  if (req_kind == KindIll) begin
                     rsp_err  <= 1'b1;
                     rsp_data <= 8'h00;
                     state    <= StResp;
                  end else begin
                     state <= StSetup;
                  end
               end
            end
            StSetup: begin
               mem_addr  <= addr_q;
               mem_wdata <= (kind_q == KindStore) ? wdata_q : 8'h00;
               unique case (kind_q)
                  KindLoad:  mem_op_code <= 4'h0;
                  KindStore: mem_op_code <= 4'h8;
                  default:   mem_op_code <= FETCH_OPCODE;
               endcase
               wait_cnt <= LastCnt;
               state    <= StAccess;
            end
            StAccess: begin
               // First ACCESS edge only drops the enable, so addr/op_code lead it by a cycle.
               if (mem_oe_n) begin
                  mem_oe_n <= 1'b0;
               end else if (wait_cnt == 4'h0) begin
                  rsp_data  <= mem_rdata;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  mem_oe_n  <= 1'b1;
                  state     <= StResp;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            StResp: begin
               // Illegal requests arrive here with rsp_valid still low; raise it one edge later.
               if (!rsp_valid) begin
                  rsp_valid <= 1'b1;
               end else if (rsp_ready) begin
                  rsp_valid  <= 1'b0;
                  xact_count <= xact_count + 8'd1;
                  state      <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: vector table, hand-written corner cases and
// randomized transactions against a behavioural memory/response model.
module tb_mem_bus_master;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid, rsp_ready, sel;
   logic [1:0] req_kind;
   logic [3:0] req_addr;
   logic [7:0] req_wdata;

   logic       a_req_ready, a_rsp_valid, a_rsp_err, a_mem_oe_n, a_busy;
   logic [7:0] a_rsp_data, a_mem_wdata, a_mem_rdata, a_xact;
   logic [3:0] a_mem_addr, a_mem_op;
   logic       b_req_ready, b_rsp_valid, b_rsp_err, b_mem_oe_n, b_busy;
   logic [7:0] b_rsp_data, b_mem_wdata, b_mem_rdata, b_xact;
   logic [3:0] b_mem_addr, b_mem_op;

   logic [7:0] pmem [16];
   logic [7:0] dmem [16];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   mem_bus_master #(.ACCESS_CYCLES(1)) u_dut_a (
      .clk(clk), .rst(rst),
      .req_valid(req_valid & ~sel), .req_ready(a_req_ready), .req_kind(req_kind),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel), .rsp_data(a_rsp_data),
      .rsp_err(a_rsp_err), .mem_addr(a_mem_addr), .mem_oe_n(a_mem_oe_n),
      .mem_op_code(a_mem_op), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
      .busy(a_busy), .xact_count(a_xact)
   );

   mem_bus_master #(.ACCESS_CYCLES(3)) u_dut_b (
      .clk(clk), .rst(rst),
      .req_valid(req_valid & sel), .req_ready(b_req_ready), .req_kind(req_kind),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel), .rsp_data(b_rsp_data),
      .rsp_err(b_rsp_err), .mem_addr(b_mem_addr), .mem_oe_n(b_mem_oe_n),
      .mem_op_code(b_mem_op), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
      .busy(b_busy), .xact_count(b_xact)
   );

   // Memory: op 0 reads data store, op 8 writes and echoes, anything else reads program store.
   function automatic logic [7:0] mem_rd(input logic [3:0] op, input logic [3:0] a,
                                         input logic [7:0] w);
      if (op == 4'h8) return w;
      if (op == 4'h0) return dmem[a];
      return pmem[a];
   endfunction

   assign a_mem_rdata = a_mem_oe_n ? 8'hxx : mem_rd(a_mem_op, a_mem_addr, a_mem_wdata);
   assign b_mem_rdata = b_mem_oe_n ? 8'hxx : mem_rd(b_mem_op, b_mem_addr, b_mem_wdata);

   always @(posedge clk) begin
      if (!a_mem_oe_n && a_mem_op == 4'h8) dmem[a_mem_addr] <= a_mem_wdata;
   end

   logic       v_req_ready, v_rsp_valid, v_rsp_err, v_mem_oe_n, v_busy;
   logic [7:0] v_rsp_data, v_mem_wdata, v_xact;
   logic [3:0] v_mem_addr, v_mem_op;
   assign v_req_ready = sel ? b_req_ready : a_req_ready;
   assign v_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
   assign v_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
   assign v_rsp_data  = sel ? b_rsp_data  : a_rsp_data;
   assign v_mem_oe_n  = sel ? b_mem_oe_n  : a_mem_oe_n;
   assign v_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
   assign v_mem_op    = sel ? b_mem_op    : a_mem_op;
   assign v_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
   assign v_busy      = sel ? b_busy      : a_busy;
   assign v_xact      = sel ? b_xact      : a_xact;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One full transaction on the selected DUT; returns what was observed.
   task automatic xact(input logic [1:0] kind, input logic [3:0] addr, input logic [7:0] wd,
                       input int hold, output logic [7:0] data, output logic err,
                       output int lat, output int oe_cnt, output logic [3:0] op_seen,
                       output logic [7:0] wd_seen);
      int         t;
      logic [3:0] a_seen;
      t = 0;
      while (!v_req_ready && t < 20) begin
         @(posedge clk); #1; t++;
      end
      chk("req_ready before request", int'(v_req_ready), 1);
      req_valid = 1'b1; req_kind = kind; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0; req_kind = 2'($urandom); req_addr = 4'($urandom);
      req_wdata = 8'($urandom);
      lat = 0; oe_cnt = 0; op_seen = 4'h0; wd_seen = 8'h00; a_seen = 4'h0;
      while (!v_rsp_valid && lat < 40) begin
         if (!v_mem_oe_n) begin
            if (oe_cnt == 0) begin
               op_seen = v_mem_op; wd_seen = v_mem_wdata; a_seen = v_mem_addr;
            end else begin
               chk("mem_addr stable while enabled", int'(v_mem_addr), int'(a_seen));
               chk("op_code stable while enabled", int'(v_mem_op), int'(op_seen));
            end
            oe_cnt++;
         end
         @(posedge clk); #1; lat++;
      end
      if (oe_cnt > 0) chk("mem_addr during enable", int'(a_seen), int'(addr));
      chk("mem_oe_n high with response", int'(v_mem_oe_n), 1);
      data = v_rsp_data; err = v_rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("rsp_valid held", int'(v_rsp_valid), 1);
         chk("rsp_data held", int'(v_rsp_data), int'(data));
         chk("req_ready low in RESP", int'(v_req_ready), 0);
         chk("busy in RESP", int'(v_busy), 1);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_valid after handshake", int'(v_rsp_valid), 0);
      chk("req_ready after handshake", int'(v_req_ready), 1);
   endtask

   typedef struct {
      logic [1:0] kind;
      logic [3:0] addr;
      logic [7:0] wd;
      logic [7:0] exp_data;
      logic       exp_err;
      int         exp_lat;
      int         exp_oe;
      logic [3:0] exp_op;
   } vec_t;

   vec_t       vecs [6];
   logic [7:0] pm_ref [16];
   logic [7:0] dm_ref [16];

   initial begin
      logic [7:0] data, wd_seen, ed;
      logic       err, rv_seen;
      logic [3:0] op_seen;
      int         lat, oe_cnt, cnt_ref;
      logic [1:0] k;
      logic [3:0] ad;
      logic [7:0] w;

      for (int i = 0; i < 16; i++) begin
         pmem[i] = {4'(i), ~4'(i)};
         dmem[i] = 8'(i * 13 + 7);
      end
      pmem[1] = 8'h19; pmem[8] = 8'h06; dmem[8] = 8'h69;
      for (int i = 0; i < 16; i++) begin
         pm_ref[i] = pmem[i]; dm_ref[i] = dmem[i];
      end

      rst = 1'b1; sel = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_kind = 2'b00; req_addr = 4'h0; req_wdata = 8'h00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset mem_oe_n", int'(a_mem_oe_n), 1);
      chk("reset mem_addr", int'(a_mem_addr), 0);
      chk("reset mem_op_code", int'(a_mem_op), 'hF);
      chk("reset mem_wdata", int'(a_mem_wdata), 0);
      chk("reset rsp_valid", int'(a_rsp_valid), 0);
      chk("reset rsp_data", int'(a_rsp_data), 0);
      chk("reset rsp_err", int'(a_rsp_err), 0);
      chk("reset xact_count", int'(a_xact), 0);
      chk("reset req_ready", int'(a_req_ready), 1);
      chk("reset busy", int'(a_busy), 0);

      vecs[0] = '{2'b00, 4'h1, 8'h00, 8'h19, 1'b0, 3, 1, 4'hF};
      vecs[1] = '{2'b01, 4'h8, 8'h00, 8'h69, 1'b0, 3, 1, 4'h0};
      vecs[2] = '{2'b00, 4'h8, 8'h00, 8'h06, 1'b0, 3, 1, 4'hF};
      vecs[3] = '{2'b10, 4'hA, 8'h5C, 8'h5C, 1'b0, 3, 1, 4'h8};
      vecs[4] = '{2'b01, 4'hA, 8'h00, 8'h5C, 1'b0, 3, 1, 4'h0};
      vecs[5] = '{2'b11, 4'h3, 8'h77, 8'h00, 1'b1, 1, 0, 4'h0};
      for (int i = 0; i < 6; i++) begin
         xact(vecs[i].kind, vecs[i].addr, vecs[i].wd, 0, data, err, lat, oe_cnt, op_seen,
              wd_seen);
         chk("vec rsp_data", int'(data), int'(vecs[i].exp_data));
         chk("vec rsp_err", int'(err), int'(vecs[i].exp_err));
         chk("vec latency", lat, vecs[i].exp_lat);
         chk("vec oe_n low cycles", oe_cnt, vecs[i].exp_oe);
         if (vecs[i].exp_oe > 0) begin
            chk("vec op_code", int'(op_seen), int'(vecs[i].exp_op));
            chk("vec mem_wdata", int'(wd_seen),
                (vecs[i].kind == 2'b10) ? int'(vecs[i].wd) : 0);
         end
         chk("vec xact_count", int'(a_xact), i + 1);
      end
      dm_ref[4'hA] = 8'h5C;
      cnt_ref = 6;

      // Backpressure: response held for 3 cycles.
      xact(2'b01, 4'h8, 8'h00, 3, data, err, lat, oe_cnt, op_seen, wd_seen);
      cnt_ref++;
      chk("backpressure rsp_data", int'(data), 'h69);
      chk("backpressure xact_count", int'(a_xact), cnt_ref);

      // Long access window on the second instance.
      sel = 1'b1;
      xact(2'b01, 4'h8, 8'h00, 0, data, err, lat, oe_cnt, op_seen, wd_seen);
      chk("N=3 rsp_data", int'(data), 'h69);
      chk("N=3 latency", lat, 5);
      chk("N=3 oe_n low cycles", oe_cnt, 3);
      chk("N=3 xact_count", int'(b_xact), 1);
      sel = 1'b0;

      for (int n = 0; n < 40; n++) begin
         k = 2'($urandom_range(0, 3)); ad = 4'($urandom); w = 8'($urandom);
         xact(k, ad, w, int'($urandom_range(0, 2)), data, err, lat, oe_cnt, op_seen, wd_seen);
         case (k)
            2'b00:   ed = pm_ref[ad];
            2'b01:   ed = dm_ref[ad];
            2'b10:   begin dm_ref[ad] = w; ed = w; end
            default: ed = 8'h00;
         endcase
         cnt_ref++;
         chk("rand rsp_data", int'(data), int'(ed));
         chk("rand rsp_err", int'(err), (k == 2'b11) ? 1 : 0);
         chk("rand latency", lat, (k == 2'b11) ? 1 : 3);
         chk("rand oe_n low cycles", oe_cnt, (k == 2'b11) ? 0 : 1);
         chk("rand xact_count", int'(a_xact), cnt_ref & 'hFF);
      end

      // Reset during ACCESS aborts the transaction.
      req_valid = 1'b1; req_kind = 2'b01; req_addr = 4'h8;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("oe_n low before abort", int'(a_mem_oe_n), 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort mem_oe_n", int'(a_mem_oe_n), 1);
      chk("abort req_ready", int'(a_req_ready), 1);
      chk("abort busy", int'(a_busy), 0);
      chk("abort xact_count", int'(a_xact), 0);
      rv_seen = a_rsp_valid;
      rsp_ready = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         rv_seen = rv_seen | a_rsp_valid;
      end
      rsp_ready = 1'b0;
      chk("abort no response", int'(rv_seen), 0);
      chk("abort xact_count later", int'(a_xact), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
